// File: rtl/hdr_tonemap_if.sv
// Pixel stream between the HDR merge stage, the tone mapper and the display writer.
// The source side (master) drives frame pulses and log-irradiance pixels; the tone mapper (slave) returns RGB565.
interface hdr_tonemap_if;
    logic        frame_start;
    logic        frame_end;
    logic        le_valid;
    logic [7:0]  le_red;
    logic [7:0]  le_green;
    logic [7:0]  le_blue;
    logic [15:0] pixel_out;
    logic        pixel_valid;

    modport master (
        output frame_start, frame_end, le_valid, le_red, le_green, le_blue,
        input  pixel_out, pixel_valid
    );

    modport slave (
        input  frame_start, frame_end, le_valid, le_red, le_green, le_blue,
        output pixel_out, pixel_valid
    );
endinterface

// File: rtl/hdr_tonemap.sv
// Log-irradiance to RGB565 tone mapper: per-frame min/max statistics feed a serial
// restoring divider whose stretch coefficient is committed at the next frame_start.
module hdr_tonemap #(
    parameter int SCALE_FP = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hdr_tonemap_if.slave          bus,
    output logic                  div_busy,
    output logic [7:0]            coeff_min,
    output logic [8+SCALE_FP-1:0] coeff_scale
);
    localparam int W  = 8 + SCALE_FP;
    localparam int PW = 8 + W;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] DIVIDEND   = W'(255) << SCALE_FP;
    localparam logic [W-1:0] UNIT_SCALE = W'(1) << SCALE_FP;

    typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    rem;
    logic [W-1:0]  dq;
    logic [7:0]    div_range;
    logic [7:0]    div_min;
    logic          pend;
    logic [W-1:0]  pend_scale;
    logic [7:0]    pend_min;
    logic [7:0]    stat_min;
    logic [7:0]    stat_max;

    logic [7:0]    pix_min, pix_max, end_min, end_max;
    logic          launch;
    logic [8:0]    rem_sh;
    logic          rem_ge;
    logic [7:0]    rem_next;

    logic          v1;
    logic [7:0]    d_r, d_g, d_b;
    logic [W-1:0]  scale1;
    logic [PW-1:0] prod_r, prod_g, prod_b;
    logic [15:0]   pix565;

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] sub_floor(input logic [7:0] a, input logic [7:0] m);
        return (a < m) ? 8'd0 : 8'(a - m);
    endfunction

    function automatic logic [7:0] sat8(input logic [PW-1:0] p);
        return (p > PW'(255)) ? 8'hFF : p[7:0];
    endfunction

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // End-of-frame stats include a pixel arriving together with frame_end.
    always_comb begin
        pix_min = min8(min8(bus.le_red, bus.le_green), bus.le_blue);
        pix_max = max8(max8(bus.le_red, bus.le_green), bus.le_blue);
        end_min = bus.le_valid ? min8(stat_min, pix_min) : stat_min;
        end_max = bus.le_valid ? max8(stat_max, pix_max) : stat_max;
        launch  = bus.frame_end && (end_min <= end_max);
    end

    always_comb begin
        rem_sh   = {rem, dq[W-1]};
        rem_ge   = (rem_sh >= {1'b0, div_range});
        rem_next = rem_ge ? 8'(rem_sh - {1'b0, div_range}) : rem_sh[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            div_busy    <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            dq          <= '0;
            div_range   <= '0;
            div_min     <= '0;
            pend        <= 1'b0;
            pend_scale  <= '0;
            pend_min    <= '0;
            coeff_min   <= '0;
            coeff_scale <= UNIT_SCALE;
            stat_min    <= '1;
            stat_max    <= '0;
        end else begin
            if (bus.frame_start) begin
                stat_min <= bus.le_valid ? pix_min : 8'hFF;
                stat_max <= bus.le_valid ? pix_max : 8'h00;
            end else begin
                stat_min <= end_min;
                stat_max <= end_max;
            end

            if (bus.frame_start && pend) begin
                coeff_min   <= pend_min;
                coeff_scale <= pend_scale;
                pend        <= 1'b0;
            end

            // A new launch restarts any division in progress; completion sets
            // pend after a same-cycle commit cleared the previous one.
            if (launch) begin
                state     <= DIV_RUN;
                div_busy  <= 1'b1;
                cnt       <= CW'(W);
                rem       <= '0;
                dq        <= DIVIDEND;
                div_range <= (end_max == end_min) ? 8'd1 : 8'(end_max - end_min);
                div_min   <= end_min;
            end else begin
                case (state)
                    DIV_RUN: begin
                        if (cnt != '0) begin
                            rem <= rem_next;
                            dq  <= {dq[W-2:0], rem_ge};
                            cnt <= cnt - 1'b1;
                        end else begin
                            state      <= DIV_IDLE;
                            div_busy   <= 1'b0;
                            pend       <= 1'b1;
                            pend_scale <= dq;
                            pend_min   <= div_min;
                        end
                    end
                    default: begin
                        state    <= DIV_IDLE;
                        div_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        prod_r = PW'(d_r) * PW'(scale1);
        prod_g = PW'(d_g) * PW'(scale1);
        prod_b = PW'(d_b) * PW'(scale1);
        pix565 = pack565(sat8(prod_r >> SCALE_FP), sat8(prod_g >> SCALE_FP),
                         sat8(prod_b >> SCALE_FP));
    end

    // Stage 2 multiplies with the scale captured alongside the pixel in stage 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1              <= 1'b0;
            d_r             <= '0;
            d_g             <= '0;
            d_b             <= '0;
            scale1          <= UNIT_SCALE;
            bus.pixel_valid <= 1'b0;
            bus.pixel_out   <= '0;
        end else begin
            v1 <= bus.le_valid;
            if (bus.le_valid) begin
                d_r    <= sub_floor(bus.le_red, coeff_min);
                d_g    <= sub_floor(bus.le_green, coeff_min);
                d_b    <= sub_floor(bus.le_blue, coeff_min);
                scale1 <= coeff_scale;
            end
            bus.pixel_valid <= v1;
            if (v1) begin
                bus.pixel_out <= pix565;
            end
        end
    end
endmodule

// File: tb/tb_hdr_tonemap.sv
// Directed bench for hdr_tonemap: identity path, stretch, zero range, late commit,
// empty frame, divider abort and reset during a division.
module tb_hdr_tonemap;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_busy;
    logic [7:0]  coeff_min;
    logic [15:0] coeff_scale;
    int          checks = 0;
    int          errors = 0;
    int          nbusy;

    hdr_tonemap_if bus ();

    hdr_tonemap #(.SCALE_FP(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .div_busy    (div_busy),
        .coeff_min   (coeff_min),
        .coeff_scale (coeff_scale)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.le_valid = 1'b1;
        bus.le_red   = r;
        bus.le_green = g;
        bus.le_blue  = b;
        step();
        bus.le_valid = 1'b0;
    endtask

    task automatic send_check(input string tag, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [15:0] exp);
        send(r, g, b);
        step();
        chk({tag, " valid"}, 32'(bus.pixel_valid), 32'd1);
        chk({tag, " pixel"}, 32'(bus.pixel_out), 32'(exp));
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (div_busy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        count_busy(n);
        chk({tag, " idle"}, 32'(div_busy), 32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.le_valid    = 1'b0;
        bus.le_red      = '0;
        bus.le_green    = '0;
        bus.le_blue     = '0;
        repeat (3) step();
        rst_n = 1'b1;

        chk("rst pixel_out", 32'(bus.pixel_out), 32'h0);
        chk("rst pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("rst div_busy", 32'(div_busy), 32'd0);
        chk("rst coeff_min", 32'(coeff_min), 32'd0);
        chk("rst coeff_scale", 32'(coeff_scale), 32'd256);

        // Identity mapping and two-cycle latency
        send(8'd16, 8'd32, 8'd200);
        chk("ident latency1", 32'(bus.pixel_valid), 32'd0);
        step();
        chk("ident valid", 32'(bus.pixel_valid), 32'd1);
        chk("ident pixel", 32'(bus.pixel_out), 32'h1119);
        step();
        chk("ident valid drop", 32'(bus.pixel_valid), 32'd0);
        chk("ident hold", 32'(bus.pixel_out), 32'h1119);

        // Normal stretch: min 40, max 120
        pulse_start();
        send(8'd40, 8'd60, 8'd80);
        send(8'd100, 8'd120, 8'd50);
        send(8'd70, 8'd70, 8'd70);
        pulse_end();
        count_busy(nbusy);
        chk("stretch busy cycles", 32'(nbusy), 32'd17);
        chk("stretch no early commit", 32'(coeff_scale), 32'd256);
        pulse_start();
        chk("stretch coeff_min", 32'(coeff_min), 32'd40);
        chk("stretch coeff_scale", 32'(coeff_scale), 32'd816);
        send_check("stretch px1", 8'd40, 8'd80, 8'd120, 16'h03FF);
        send_check("stretch px2", 8'd30, 8'd30, 8'd30, 16'h0000);

        // Zero range
        pulse_start();
        send(8'd100, 8'd100, 8'd100);
        send(8'd100, 8'd100, 8'd100);
        pulse_end();
        wait_idle("zero");
        pulse_start();
        chk("zero coeff_min", 32'(coeff_min), 32'd100);
        chk("zero coeff_scale", 32'(coeff_scale), 32'd65280);
        send_check("zero px sat", 8'd100, 8'd101, 8'd102, 16'h07FF);

        // Late commit: frame_start while the divider is still running
        pulse_start();
        send(8'd40, 8'd80, 8'd120);
        send(8'd60, 8'd60, 8'd60);
        pulse_end();
        repeat (4) step();
        pulse_start();
        chk("late busy at start", 32'(div_busy), 32'd1);
        chk("late old coeff_min", 32'(coeff_min), 32'd100);
        chk("late old coeff_scale", 32'(coeff_scale), 32'd65280);
        send_check("late px old coeff", 8'd100, 8'd101, 8'd102, 16'h07FF);
        wait_idle("late");
        chk("late still old", 32'(coeff_scale), 32'd65280);
        pulse_start();
        chk("late commit min", 32'(coeff_min), 32'd40);
        chk("late commit scale", 32'(coeff_scale), 32'd816);

        // Empty frame: no launch
        pulse_start();
        pulse_end();
        chk("empty busy", 32'(div_busy), 32'd0);
        step();
        chk("empty busy later", 32'(div_busy), 32'd0);
        pulse_start();
        chk("empty coeff_min", 32'(coeff_min), 32'd40);
        chk("empty coeff_scale", 32'(coeff_scale), 32'd816);

        // Abort: first frame range 20, second frame (min 50, max 150) ends 6 cycles in
        pulse_start();
        send(8'd10, 8'd20, 8'd30);
        pulse_end();
        pulse_start();
        send(8'd50, 8'd100, 8'd150);
        repeat (3) step();
        chk("abort busy before", 32'(div_busy), 32'd1);
        pulse_end();
        count_busy(nbusy);
        chk("abort busy cycles", 32'(nbusy), 32'd17);
        pulse_start();
        chk("abort coeff_min", 32'(coeff_min), 32'd50);
        chk("abort coeff_scale", 32'(coeff_scale), 32'd652);
        send_check("abort px", 8'd60, 8'd60, 8'd60, 16'h18C3);

        // Reset at division cycle 8 with a pixel in flight
        send(8'd20, 8'd40, 8'd60);
        pulse_end();
        repeat (6) step();
        send(8'd90, 8'd90, 8'd90);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid-rst div_busy", 32'(div_busy), 32'd0);
        chk("mid-rst pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("mid-rst coeff_scale", 32'(coeff_scale), 32'd256);
        chk("mid-rst coeff_min", 32'(coeff_min), 32'd0);
        step();
        chk("mid-rst flushed", 32'(bus.pixel_valid), 32'd0);
        repeat (20) step();
        chk("mid-rst busy stays low", 32'(div_busy), 32'd0);
        pulse_start();
        chk("mid-rst no commit scale", 32'(coeff_scale), 32'd256);
        chk("mid-rst no commit min", 32'(coeff_min), 32'd0);
        send_check("mid-rst ident px", 8'd16, 8'd32, 8'd200, 16'h1119);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdr_tonemap.md
Name: hdr_tonemap

Overview:
- Downstream consumer of the HDR merge stage.
- Takes the per-pixel log-irradiance triple (8-bit unsigned, 4 fractional bits) plus its done strobe and produces displayable RGB565.
- Tracks per-frame min/max of log irradiance across all three channels. At frame end, a multi-cycle serial divider computes a linear stretch coefficient, which is applied to the next frame.
- Output feeds the display/frame-buffer writer.

Parameters:
- SCALE_FP, 8, fractional bits of the scale coefficient. Dividend = 255 << SCALE_FP, 8+SCALE_FP bits wide.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- frame_start  input  1  one-cycle pulse: new frame begins
- frame_end  input  1  one-cycle pulse: last pixel of frame delivered
- le_valid  input  1  pixel strobe (driven by HDR done pulse)
- le_red  input  8  log irradiance, red
- le_green  input  8  log irradiance, green
- le_blue  input  8  log irradiance, blue
- pixel_out  output  16  RGB565 {R[4:0],G[5:0],B[4:0]}
- pixel_valid  output  1  pixel_out valid
- div_busy  output  1  divider running
- coeff_min  output  8  active offset
- coeff_scale  output  8+SCALE_FP  active scale

Behaviour:
- Reset values:
  - pixel_out=0, pixel_valid=0, div_busy=0.
  - coeff_min=0, coeff_scale=1<<SCALE_FP (identity: n=lE).
  - stats min=255, max=0; pending flag=0.
- Datapath, 2-cycle latency; pixel_valid = le_valid delayed 2 cycles. Fully pipelined, one pixel per cycle, no backpressure.
  - Stage 1, per channel: d = (lE < coeff_min) ? 0 : lE - coeff_min (8 bits).
  - Stage 2, per channel: p = (d * coeff_scale) >> SCALE_FP, computed at full width (8+8+SCALE_FP bits); n = min(p, 255).
  - Packing: R=n_r[7:3], G=n_g[7:2], B=n_b[7:3].
  - pixel_out holds its last value when pixel_valid=0.
- Statistics:
  - frame_start loads min=255, max=0.
  - Each le_valid updates min/max with min and max of the three channels.
  - A pixel coincident with frame_start counts toward the new frame.
  - A pixel coincident with frame_end counts toward the ending frame.
- Divider launch at frame_end:
  - If stats min>max (no valid pixels): no launch; coefficients and pending unchanged.
  - Otherwise latch range = max-min (range 0 treated as 1) and latched min; div_busy=1 next cycle.
- Divider operation:
  - Restoring, one quotient bit per cycle, 8+SCALE_FP iterations.
  - Quotient = floor((255<<SCALE_FP)/range).
  - div_busy falls the cycle after the last iteration, i.e. 1+8+SCALE_FP cycles after frame_end (17 at default).
  - Result is written to pending_scale/pending_min and sets pending=1.
- frame_end while div_busy: current division aborted and restarted with the new stats.
- Commit at frame_start:
  - If the registered pending=1, coeff_min/coeff_scale load the pending values and pending clears.
  - Otherwise the active coefficients are kept.
  - Divider completing in the same cycle as frame_start does not commit; it commits at the following frame_start.
  - Coefficient change affects pixels entering stage 1 from the cycle after frame_start. In-flight pixels use the coefficients they entered with: stage 2 uses a per-stage copy of coeff_scale.
- frame_start and frame_end in the same cycle: processed as frame_end of the old frame (stats latched), then stats re-initialised.
- Reset mid-operation: divider aborted, pending cleared, all values to reset state; the pipeline is flushed, so pixel_valid=0 the next cycle.

Test Plan:
- Identity after reset: le_valid with (16,32,200) -> two cycles later pixel_valid=1, pixel_out=0x1119.
- Normal stretch:
  - Stimulus: frame of pixels spanning min 40 / max 120, then frame_end.
  - Expected: div_busy high exactly 17 cycles; at next frame_start coeff_min=40, coeff_scale=816.
  - Then pixel (40,80,120) -> 0x03FF; pixel (30,30,30) -> 0x0000.
- Zero range:
  - Stimulus: frame with all channels 100.
  - Expected: coeff_scale=65280, coeff_min=100. Next frame (100,101,102) -> n=(0,255,255 saturated) -> 0x07FF.
- Late commit:
  - Stimulus: frame_end, then frame_start 5 cycles later.
  - Expected: that frame still uses old coefficients; a further frame_start after div_busy falls commits 816/40.
- Empty frame and abort:
  - Empty frame: frame_start then frame_end with no le_valid -> div_busy stays 0, coefficients unchanged.
  - Abort: second frame_end 6 cycles into a division -> div_busy stays high 17 cycles from the second pulse; result reflects the second frame's stats.
- Reset mid-division: rst_n low 1 cycle at division cycle 8 -> div_busy=0, pixel_valid=0, coeff_scale=256, coeff_min=0; subsequent frame_start commits nothing.
